ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
Execute-side counterpart of the ID-stage decoder. Accepts the 11-bit control word, rd and rs fields from ID each cycle and carries them through the ID/EX, EX/MEM and MEM/WB registers. Computes registered forwarding selects against the in-flight rd scoreboard, detects load-use hazards (stall plus bubble) and squashes on a taken branch. Sits between the decoder and the EX/MEM/WB datapath muxes and replaces decode-side rd tracking with clocked state.

Parameters:
CTRL_W, 11, control word width {ImmSel[10:8], RegWEn[7], ALUSel[6:3], MemRW[2], WBSel[1:0]}
RA_W, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_ctrl  in  CTRL_W  decoded control word
id_rd  in  RA_W  destination register
id_rs1  in  RA_W  source 1
id_rs2  in  RA_W  source 2
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_pc_a  in  1  operand A is PC (branch, JAL, AUIPC)
id_imm_b  in  1  operand B is immediate
ex_br_taken  in  1  EX resolved a taken branch/jump this cycle
stall  out  1  freeze PC and IF/ID (combinational)
flush  out  1  squash IF/ID (equals ex_br_taken)
ex_alusel  out  4  ALUSel in EX
ex_opa  out  2  00 rs1, 01 PC, 10 EX/MEM fwd, 11 MEM/WB fwd
ex_opb  out  2  00 rs2, 01 imm, 10 EX/MEM fwd, 11 MEM/WB fwd
ex_sw_sel  out  2  store-data select: 0 rs2, 1 EX/MEM fwd, 2 MEM/WB fwd
mem_memrw  out  1  data-memory write enable (MEM stage)
wb_regwen  out  1  register-file write enable
wb_wbsel  out  2  00 mem, 01 ALU, 10 PC+4
wb_rd  out  RA_W  write-back address

Behaviour:
- Reset (async): all stage valids 0, all control fields 0, rd fields 0; every output 0; stall=0 while reset asserted.
- Stage write qualifiers: stage X "writes r" iff X.valid & X.RegWEn & X.rd==r & r!=0. Bubbles never write, never match.
- Forward compute (comb, at ID, registered into EX): for each used rs, compare against the EX-stage instruction first (code 10), then MEM-stage (code 11); nearer wins; else 00. Unused rs gives 00.
- ex_opa: 01 if id_pc_a, else rs1 forward code. ex_opb: 01 if id_imm_b (also store), else rs2 forward code.
- ex_sw_sel: only for stores (MemRW=1): rs2 forward code mapped 10->1, 11->2, 00->0; otherwise 0.
- Both operands may forward independently in the same cycle (e.g. rs1 from EX/MEM, rs2 from MEM/WB).
- Load-use: EX stage valid, RegWEn=1, WBSel=00, MemRW=0 and EX.rd matches a used id_rs (rd!=0) -> stall=1 this cycle; EX loads a bubble; ID contents are held by the upstream stage (this block does not re-register them). One-cycle stall only; next cycle the load is in MEM and the dependency forwards via code 11.
- Flush: ex_br_taken=1 -> EX loads a bubble regardless of stall; stall forced 0 (the dependent instruction is being squashed). MEM/WB advance normally; the branch itself continues.
- Latency: ID fields appear on ex_* one cycle later, mem_memrw two cycles later, wb_* three cycles later. No back-pressure beyond stall.
- id_valid=0 loads a bubble (valid 0, RegWEn 0, MemRW 0).
- Reset mid-operation clears all stages immediately; the first post-reset instruction sees no forwarding.
- Bubble outputs: ex_opa=ex_opb=00, ex_sw_sel=0, ex_alusel=0.

Decomposition:
- Shared package rv_ctrl_pkg: control-word field bit positions, WBSel encodings (WB_MEM, WB_ALU, WB_PC4), opA/opB codes, sw_sel codes, BUBBLE constant.
- One sub-module: fwd_cmp (a single rs against the EX/MEM/WB rd set -> 2-bit code), instantiated twice.
- Stage registers stay inline.

Test Plan:
- add x5,x1,x2 ; add x6,x5,x3 -> second instr ex_opa=10, ex_opb=00; x6 reaches wb_rd=6, wb_regwen=1, wb_wbsel=01 three cycles after ID.
- add x5,.. ; nop ; sub x7,x4,x5 -> sub ex_opb=11, ex_opa=00.
- lw x8,0(x1) ; addi x9,x8,4 -> stall=1 exactly one cycle, EX bubble, then addi ex_opa=11, ex_opb=01.
- add x10,.. ; sw x10,8(x2) -> ex_sw_sel=1, ex_opb=01, mem_memrw=1 two cycles after ID; with one intervening nop, ex_sw_sel=2.
- lw x8 ; add x3,x8,x8 with ex_br_taken=1 same cycle -> stall=0, flush=1, EX bubble; write to x0 (rd=0) followed by a reader -> no forward (00).
- rst asserted mid-stream with valid stages -> all outputs 0 immediately; first instruction after release uses 00 selects.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the execute-side control pipeline:
//   - control-word layout {ImmSel[10:8], RegWEn[7], ALUSel[6:3], MemRW[2], WBSel[1:0]}
//   - write-back select encodings
//   - operand-select and store-data-select codes
//   - the all-zero bubble control word
// -----------------------------------------------------------------------------
package rv_ctrl_pkg;

   localparam int RV_CTRL_W = 11;
   localparam int RV_RA_W   = 5;

   // Control-word field positions
   localparam int IMMSEL_HI  = 10;
   localparam int IMMSEL_LO  = 8;
   localparam int REGWEN_BIT = 7;
   localparam int ALUSEL_HI  = 6;
   localparam int ALUSEL_LO  = 3;
   localparam int MEMRW_BIT  = 2;
   localparam int WBSEL_HI   = 1;
   localparam int WBSEL_LO   = 0;

   typedef enum logic [1:0] {
      WB_MEM = 2'b00,
      WB_ALU = 2'b01,
      WB_PC4 = 2'b10
   } wbsel_e;

   // Operand select: OP_ALT means PC for operand A, immediate for operand B
   typedef enum logic [1:0] {
      OP_REG       = 2'b00,
      OP_ALT       = 2'b01,
      OP_FWD_EXMEM = 2'b10,
      OP_FWD_MEMWB = 2'b11
   } op_sel_e;

   typedef enum logic [1:0] {
      SW_RS2       = 2'd0,
      SW_FWD_EXMEM = 2'd1,
      SW_FWD_MEMWB = 2'd2
   } sw_sel_e;

   // A bubble carries no write, no store and zero select fields
   localparam logic [RV_CTRL_W-1:0] BUBBLE = '0;

   // Store data uses a compact encoding of the same forwarding decision
   function automatic logic [1:0] sw_sel_from_fwd(input logic [1:0] fwd);
      logic [1:0] sel;
      case (fwd)
         OP_FWD_EXMEM: sel = SW_FWD_EXMEM;
         OP_FWD_MEMWB: sel = SW_FWD_MEMWB;
         default:      sel = SW_RS2;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/fwd_cmp.sv
// -----------------------------------------------------------------------------
// fwd_cmp
// Compares one source register of the ID-stage instruction against the
// destinations of the instructions currently in EX and MEM and returns the
// operand forwarding code it will need once it reaches EX.
//   rs, use_rs     : source register and whether the instruction reads it
//   ex_wr, ex_rd   : EX-stage instruction writes the register file / its rd
//   mem_wr, mem_rd : MEM-stage instruction writes the register file / its rd
//   code           : OP_FWD_EXMEM, OP_FWD_MEMWB or OP_REG
// -----------------------------------------------------------------------------
module fwd_cmp
   import rv_ctrl_pkg::*;
#(
   parameter int RA_W = RV_RA_W
) (
   input  logic [RA_W-1:0] rs,
   input  logic            use_rs,
   input  logic            ex_wr,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            mem_wr,
   input  logic [RA_W-1:0] mem_rd,
   output logic [1:0]      code
);

   logic live;

   // x0 is hard-wired, so a reader of x0 never forwards
   assign live = use_rs & (rs != '0);

   // The EX-stage instruction is younger than the MEM-stage one, so it wins
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves code unassigned (no latch).
      code = OP_REG;
      if (live && ex_wr && (ex_rd == rs)) begin
         code = OP_FWD_EXMEM;
      end else if (live && mem_wr && (mem_rd == rs)) begin
         code = OP_FWD_MEMWB;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_pipe
// Carries the decoded control word and rd through ID/EX, EX/MEM and MEM/WB,
// registers forwarding selects for EX, detects load-use hazards and squashes
// the ID instruction on a taken branch.
// Inputs : clk, rst (async, active high), id_valid, id_ctrl, id_rd, id_rs1,
//          id_rs2, id_use_rs1, id_use_rs2, id_pc_a, id_imm_b, ex_br_taken
// Outputs: stall, flush (combinational); ex_alusel, ex_opa, ex_opb, ex_sw_sel
//          (EX); mem_memrw (MEM); wb_regwen, wb_wbsel, wb_rd (WB)
// -----------------------------------------------------------------------------
module ctrl_pipe
   import rv_ctrl_pkg::*;
#(
   parameter int CTRL_W = RV_CTRL_W,
   parameter int RA_W   = RV_RA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [RA_W-1:0]   id_rd,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_pc_a,
   input  logic              id_imm_b,
   input  logic              ex_br_taken,
   output logic              stall,
   output logic              flush,
   output logic [3:0]        ex_alusel,
   output logic [1:0]        ex_opa,
   output logic [1:0]        ex_opb,
   output logic [1:0]        ex_sw_sel,
   output logic              mem_memrw,
   output logic              wb_regwen,
   output logic [1:0]        wb_wbsel,
   output logic [RA_W-1:0]   wb_rd
);

   // ID/EX register
   logic            ex_valid_q,  ex_valid_d;
   logic            ex_regwen_q, ex_regwen_d;
   logic [3:0]      ex_alusel_q, ex_alusel_d;
   logic            ex_memrw_q,  ex_memrw_d;
   logic [1:0]      ex_wbsel_q,  ex_wbsel_d;
   logic [RA_W-1:0] ex_rd_q,     ex_rd_d;
   logic [1:0]      ex_opa_q,    ex_opa_d;
   logic [1:0]      ex_opb_q,    ex_opb_d;
   logic [1:0]      ex_sw_sel_q, ex_sw_sel_d;

   // EX/MEM register
   logic            mem_valid_q,  mem_valid_d;
   logic            mem_regwen_q, mem_regwen_d;
   logic            mem_memrw_q,  mem_memrw_d;
   logic [1:0]      mem_wbsel_q,  mem_wbsel_d;
   logic [RA_W-1:0] mem_rd_q,     mem_rd_d;

   // MEM/WB register
   logic            wb_regwen_q, wb_regwen_d;
   logic [1:0]      wb_wbsel_q,  wb_wbsel_d;
   logic [RA_W-1:0] wb_rd_q,     wb_rd_d;

   logic [1:0]        rs1_fwd;
   logic [1:0]        rs2_fwd;
   logic              ex_wr;
   logic              mem_wr;
   logic              ex_is_load;
   logic              load_use;
   logic              kill;
   logic [CTRL_W-1:0] id_word;
   logic              unused_immsel;

   // ImmSel is consumed by the immediate generator, not by this block
   assign unused_immsel = ^id_ctrl[IMMSEL_HI:IMMSEL_LO];

   assign ex_wr  = ex_valid_q & ex_regwen_q;
   assign mem_wr = mem_valid_q & mem_regwen_q;

   fwd_cmp #(.RA_W(RA_W)) u_fwd_rs1 (
      .rs     (id_rs1),
      .use_rs (id_use_rs1),
      .ex_wr  (ex_wr),
      .ex_rd  (ex_rd_q),
      .mem_wr (mem_wr),
      .mem_rd (mem_rd_q),
      .code   (rs1_fwd)
   );

   fwd_cmp #(.RA_W(RA_W)) u_fwd_rs2 (
      .rs     (id_rs2),
      .use_rs (id_use_rs2),
      .ex_wr  (ex_wr),
      .ex_rd  (ex_rd_q),
      .mem_wr (mem_wr),
      .mem_rd (mem_rd_q),
      .code   (rs2_fwd)
   );

   // A load's data is not available at EX/MEM, so an EX-distance match on a
   // load cannot forward and the dependent must wait one cycle.
   assign ex_is_load = ex_wr & (ex_wbsel_q == WB_MEM) & ~ex_memrw_q;
   assign load_use   = id_valid & ex_is_load &
                       ((rs1_fwd == OP_FWD_EXMEM) | (rs2_fwd == OP_FWD_EXMEM));

   // A taken branch squashes the dependent, so there is nothing to stall for
   assign stall = load_use & ~ex_br_taken & ~rst;
   assign flush = ex_br_taken & ~rst;

   // Anything that must not enter EX becomes a bubble
   assign kill    = ~id_valid | load_use | ex_br_taken;
   assign id_word = kill ? BUBBLE : id_ctrl;

   always_comb begin
      ex_valid_d  = ~kill;
      ex_regwen_d = id_word[REGWEN_BIT];
      ex_alusel_d = id_word[ALUSEL_HI:ALUSEL_LO];
      ex_memrw_d  = id_word[MEMRW_BIT];
      ex_wbsel_d  = id_word[WBSEL_HI:WBSEL_LO];
      ex_rd_d     = '0;
      ex_opa_d    = OP_REG;
      ex_opb_d    = OP_REG;
      ex_sw_sel_d = SW_RS2;
      if (!kill) begin
         ex_rd_d  = id_rd;
         ex_opa_d = id_pc_a  ? OP_ALT : rs1_fwd;
         ex_opb_d = id_imm_b ? OP_ALT : rs2_fwd;
         // Stores take the immediate on operand B; rs2 is the store data
         if (id_ctrl[MEMRW_BIT]) begin
            ex_sw_sel_d = sw_sel_from_fwd(rs2_fwd);
         end
      end

      mem_valid_d  = ex_valid_q;
      mem_regwen_d = ex_regwen_q;
      mem_memrw_d  = ex_memrw_q;
      mem_wbsel_d  = ex_wbsel_q;
      mem_rd_d     = ex_rd_q;

      wb_regwen_d  = mem_regwen_q;
      wb_wbsel_d   = mem_wbsel_q;
      wb_rd_d      = mem_rd_q;
   end

   // NOTE: non-blocking assignments so every stage samples its predecessor's old value on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_regwen_q  <= 1'b0;
         ex_alusel_q  <= '0;
         ex_memrw_q   <= 1'b0;
         ex_wbsel_q   <= '0;
         ex_rd_q      <= '0;
         ex_opa_q     <= '0;
         ex_opb_q     <= '0;
         ex_sw_sel_q  <= '0;
         mem_valid_q  <= 1'b0;
         mem_regwen_q <= 1'b0;
         mem_memrw_q  <= 1'b0;
         mem_wbsel_q  <= '0;
         mem_rd_q     <= '0;
         wb_regwen_q  <= 1'b0;
         wb_wbsel_q   <= '0;
         wb_rd_q      <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_regwen_q  <= ex_regwen_d;
         ex_alusel_q  <= ex_alusel_d;
         ex_memrw_q   <= ex_memrw_d;
         ex_wbsel_q   <= ex_wbsel_d;
         ex_rd_q      <= ex_rd_d;
         ex_opa_q     <= ex_opa_d;
         ex_opb_q     <= ex_opb_d;
         ex_sw_sel_q  <= ex_sw_sel_d;
         mem_valid_q  <= mem_valid_d;
         mem_regwen_q <= mem_regwen_d;
         mem_memrw_q  <= mem_memrw_d;
         mem_wbsel_q  <= mem_wbsel_d;
         mem_rd_q     <= mem_rd_d;
         wb_regwen_q  <= wb_regwen_d;
         wb_wbsel_q   <= wb_wbsel_d;
         wb_rd_q      <= wb_rd_d;
      end
   end

   assign ex_alusel = ex_alusel_q;
   assign ex_opa    = ex_opa_q;
   assign ex_opb    = ex_opb_q;
   assign ex_sw_sel = ex_sw_sel_q;
   assign mem_memrw = mem_memrw_q;
   assign wb_regwen = wb_regwen_q;
   assign wb_wbsel  = wb_wbsel_q;
   assign wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipe
// Directed hazard scenarios followed by random instruction streams, checked
// every cycle against a history-based reference model of the pipeline.
// -----------------------------------------------------------------------------
module tb_ctrl_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [10:0] id_ctrl;
   logic [4:0]  id_rd, id_rs1, id_rs2;
   logic        id_use_rs1, id_use_rs2, id_pc_a, id_imm_b, ex_br_taken;
   logic        stall, flush;
   logic [3:0]  ex_alusel;
   logic [1:0]  ex_opa, ex_opb, ex_sw_sel;
   logic        mem_memrw, wb_regwen;
   logic [1:0]  wb_wbsel;
   logic [4:0]  wb_rd;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ctrl_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_ctrl    (id_ctrl),
      .id_rd      (id_rd),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .id_pc_a    (id_pc_a),
      .id_imm_b   (id_imm_b),
      .ex_br_taken(ex_br_taken),
      .stall      (stall),
      .flush      (flush),
      .ex_alusel  (ex_alusel),
      .ex_opa     (ex_opa),
      .ex_opb     (ex_opb),
      .ex_sw_sel  (ex_sw_sel),
      .mem_memrw  (mem_memrw),
      .wb_regwen  (wb_regwen),
      .wb_wbsel   (wb_wbsel),
      .wb_rd      (wb_rd)
   );

   typedef struct {
      bit        valid;
      bit [10:0] ctrl;
      bit [4:0]  rd, rs1, rs2;
      bit        u1, u2, pca, immb;
   } instr_t;

   // What entered EX in a given cycle; hist[0] is in EX, [1] in MEM, [2] in WB
   typedef struct {
      bit       valid;
      bit       regwen;
      bit [3:0] alusel;
      bit       memrw;
      bit [1:0] wbsel;
      bit [4:0] rd;
      bit [1:0] opa, opb, sw;
   } ent_t;

   ent_t hist[$];

   function automatic ent_t bubble_ent();
      ent_t e;
      e = '{default: 0};
      return e;
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (3) hist.push_back(bubble_ent());
   endtask

   function automatic bit writes(ent_t e, bit [4:0] r);
      return e.valid && e.regwen && (e.rd == r) && (r != 0);
   endfunction

   // Distance to the nearest in-flight writer decides where the value lives
   function automatic bit [1:0] src_code(bit reads, bit [4:0] r);
      if (!reads || r == 0) return 2'b00;
      if (writes(hist[0], r)) return 2'b10;
      if (writes(hist[1], r)) return 2'b11;
      return 2'b00;
   endfunction

   function automatic instr_t mk(bit v, bit [2:0] imm, bit we, bit [3:0] alu, bit mw,
                                 bit [1:0] wb, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                                 bit u1, bit u2, bit pca, bit immb);
      instr_t i;
      i.valid = v;
      i.ctrl  = {imm, we, alu, mw, wb};
      i.rd    = rd;
      i.rs1   = rs1;
      i.rs2   = rs2;
      i.u1    = u1;
      i.u2    = u2;
      i.pca   = pca;
      i.immb  = immb;
      return i;
   endfunction

   function automatic instr_t alu_op(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2, bit [3:0] alu);
      return mk(1, 3'd0, 1, alu, 0, 2'b01, rd, rs1, rs2, 1, 1, 0, 0);
   endfunction
   function automatic instr_t alu_imm(bit [4:0] rd, bit [4:0] rs1);
      return mk(1, 3'd1, 1, 4'd0, 0, 2'b01, rd, rs1, 5'd0, 1, 0, 0, 1);
   endfunction
   function automatic instr_t load(bit [4:0] rd, bit [4:0] rs1);
      return mk(1, 3'd1, 1, 4'd0, 0, 2'b00, rd, rs1, 5'd0, 1, 0, 0, 1);
   endfunction
   function automatic instr_t store(bit [4:0] rs1, bit [4:0] rs2);
      return mk(1, 3'd2, 0, 4'd0, 1, 2'b00, 5'd0, rs1, rs2, 1, 1, 0, 1);
   endfunction
   function automatic instr_t nop();
      return mk(0, 3'd0, 0, 4'd0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
   endfunction

   function automatic instr_t rand_instr();
      bit [4:0] rd, r1, r2;
      bit [3:0] alu;
      instr_t   i;
      rd  = 5'($urandom_range(0, 3));
      r1  = 5'($urandom_range(0, 3));
      r2  = 5'($urandom_range(0, 3));
      alu = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
         0:       i = alu_op(rd, r1, r2, alu);
         1:       i = alu_imm(rd, r1);
         2:       i = load(rd, r1);
         3:       i = store(r1, r2);
         4:       i = mk(1, 3'd3, 0, alu, 0, 2'b00, 5'd0, r1, r2, 1, 1, 1, 1);  // branch
         default: i = mk(1, 3'd4, 1, 4'd0, 0, 2'b10, rd, 5'd0, 5'd0, 0, 0, 1, 1); // jal
      endcase
      i.valid = ($urandom_range(0, 9) != 0);
      return i;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input instr_t in, input bit br);
      id_valid    = in.valid;
      id_ctrl     = in.ctrl;
      id_rd       = in.rd;
      id_rs1      = in.rs1;
      id_rs2      = in.rs2;
      id_use_rs1  = in.u1;
      id_use_rs2  = in.u2;
      id_pc_a     = in.pca;
      id_imm_b    = in.immb;
      ex_br_taken = br;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"},  stall,     0);
      check({tag, "_flush"},  flush,     0);
      check({tag, "_alusel"}, ex_alusel, 0);
      check({tag, "_opa"},    ex_opa,    0);
      check({tag, "_opb"},    ex_opb,    0);
      check({tag, "_swsel"},  ex_sw_sel, 0);
      check({tag, "_memrw"},  mem_memrw, 0);
      check({tag, "_regwen"}, wb_regwen, 0);
      check({tag, "_wbsel"},  wb_wbsel,  0);
      check({tag, "_wbrd"},   wb_rd,     0);
   endtask

   // One ID cycle: drive, check against the model mid-cycle, then advance
   task automatic step(input instr_t in, input bit br);
      ent_t     ex_e, m_e, w_e, n;
      bit [1:0] c1, c2;
      bit       lu;
      drive(in, br);
      @(negedge clk);
      ex_e = hist[0];
      m_e  = hist[1];
      w_e  = hist[2];
      lu = in.valid && ex_e.valid && ex_e.regwen && ex_e.wbsel == 2'b00 && !ex_e.memrw &&
           ex_e.rd != 0 &&
           ((in.u1 && in.rs1 == ex_e.rd) || (in.u2 && in.rs2 == ex_e.rd));
      check("stall",     stall,     lu && !br);
      check("flush",     flush,     br);
      check("ex_alusel", ex_alusel, ex_e.alusel);
      check("ex_opa",    ex_opa,    ex_e.opa);
      check("ex_opb",    ex_opb,    ex_e.opb);
      check("ex_sw_sel", ex_sw_sel, ex_e.sw);
      check("mem_memrw", mem_memrw, m_e.valid && m_e.memrw);
      check("wb_regwen", wb_regwen, w_e.valid && w_e.regwen);
      check("wb_wbsel",  wb_wbsel,  w_e.wbsel);
      check("wb_rd",     wb_rd,     w_e.rd);
      c1 = src_code(in.u1, in.rs1);
      c2 = src_code(in.u2, in.rs2);
      n  = bubble_ent();
      if (in.valid && !lu && !br) begin
         n.valid  = 1;
         n.regwen = in.ctrl[7];
         n.alusel = in.ctrl[6:3];
         n.memrw  = in.ctrl[2];
         n.wbsel  = in.ctrl[1:0];
         n.rd     = in.rd;
         n.opa    = in.pca  ? 2'b01 : c1;
         n.opb    = in.immb ? 2'b01 : c2;
         n.sw     = !in.ctrl[2] ? 2'd0 : (c2 == 2'b10) ? 2'd1 : (c2 == 2'b11) ? 2'd2 : 2'd0;
      end
      @(posedge clk);
      #1;
      hist.push_front(n);
      void'(hist.pop_back());
   endtask

   // Reset pulse asserted mid-cycle while the pipe is busy
   task automatic mid_reset(input string tag);
      drive(alu_op(5'd3, 5'd1, 5'd2, 4'd9), 1'b1);
      #1 rst = 1'b1;
      #1 check_all_zero(tag);
      model_reset();
      @(posedge clk);
      #1;
      rst         = 1'b0;
      ex_br_taken = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(nop(), 1'b1);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      drive(nop(), 1'b0);

      // Back-to-back dependency forwards from EX/MEM; x6 reaches WB 3 cycles on
      step(alu_op(5'd5, 5'd1, 5'd2, 4'd0), 0);
      step(alu_op(5'd6, 5'd5, 5'd3, 4'd0), 0);
      check("t1_opa", ex_opa, 2'b10);
      check("t1_opb", ex_opb, 2'b00);
      step(nop(), 0);
      step(nop(), 0);
      check("t1_wb_rd",     wb_rd,     5'd6);
      check("t1_wb_regwen", wb_regwen, 1'b1);
      check("t1_wb_wbsel",  wb_wbsel,  2'b01);

      // One instruction between writer and reader forwards from MEM/WB
      step(alu_op(5'd5, 5'd1, 5'd2, 4'd0), 0);
      step(nop(), 0);
      step(alu_op(5'd7, 5'd4, 5'd5, 4'd8), 0);
      check("t2_opa", ex_opa, 2'b00);
      check("t2_opb", ex_opb, 2'b11);
      check("t2_alusel", ex_alusel, 4'd8);

      // Load-use: one stall cycle with a bubble, then MEM/WB forward
      step(load(5'd8, 5'd1), 0);
      drive(alu_imm(5'd9, 5'd8), 0);
      #1 check("t3_stall_hi", stall, 1'b1);
      step(alu_imm(5'd9, 5'd8), 0);
      check("t3_bubble_opa", ex_opa, 2'b00);
      check("t3_bubble_opb", ex_opb, 2'b00);
      drive(alu_imm(5'd9, 5'd8), 0);
      #1 check("t3_stall_lo", stall, 1'b0);
      step(alu_imm(5'd9, 5'd8), 0);
      check("t3_opa", ex_opa, 2'b11);
      check("t3_opb", ex_opb, 2'b01);

      // Store data forwarding at both distances
      step(alu_op(5'd10, 5'd1, 5'd2, 4'd0), 0);
      step(store(5'd2, 5'd10), 0);
      check("t4_swsel1", ex_sw_sel, 2'd1);
      check("t4_opb",    ex_opb,    2'b01);
      step(nop(), 0);
      check("t4_memrw",  mem_memrw, 1'b1);
      step(alu_op(5'd10, 5'd1, 5'd2, 4'd0), 0);
      step(nop(), 0);
      step(store(5'd2, 5'd10), 0);
      check("t4_swsel2", ex_sw_sel, 2'd2);

      // Taken branch beats a load-use stall and squashes the ID instruction
      step(load(5'd8, 5'd1), 0);
      drive(alu_op(5'd3, 5'd8, 5'd8, 4'd0), 1);
      #1 check("t5_stall", stall, 1'b0);
      check("t5_flush", flush, 1'b1);
      step(alu_op(5'd3, 5'd8, 5'd8, 4'd0), 1);
      check("t5_bubble_opa", ex_opa, 2'b00);
      step(alu_op(5'd11, 5'd1, 5'd2, 4'd5), 1);
      check("t5_flush_alusel", ex_alusel, 4'd0);
      step(nop(), 0);
      check("t5_flush_no_write", wb_regwen, 1'b0);

      // Writes to x0 are never forwarded
      step(alu_op(5'd0, 5'd1, 5'd2, 4'd0), 0);
      step(alu_op(5'd12, 5'd0, 5'd0, 4'd0), 0);
      check("t6_x0_opa", ex_opa, 2'b00);
      check("t6_x0_opb", ex_opb, 2'b00);

      // Independent forwarding of both operands in one cycle
      step(alu_op(5'd13, 5'd1, 5'd2, 4'd0), 0);
      step(alu_op(5'd14, 5'd1, 5'd2, 4'd0), 0);
      step(alu_op(5'd15, 5'd14, 5'd13, 4'd0), 0);
      check("t7_opa", ex_opa, 2'b10);
      check("t7_opb", ex_opb, 2'b11);

      // Reset mid-stream, then the first instruction sees no forwarding
      step(alu_op(5'd16, 5'd1, 5'd2, 4'd0), 0);
      step(load(5'd17, 5'd16), 0);
      mid_reset("t8_rst");
      step(alu_op(5'd19, 5'd16, 5'd17, 4'd0), 0);
      check("t8_opa", ex_opa, 2'b00);
      check("t8_opb", ex_opb, 2'b00);

      // Random streams over a small register set to make hazards frequent
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            mid_reset("rnd_rst");
         end else begin
            step(rand_instr(), ($urandom_range(0, 9) == 0));
         end
      end
      repeat (3) step(nop(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
